// File: rtl/if_controller_pkg.sv
// Shared controller types: the input-feature FSM states and the array drain-length helpers.
// The weight-controller types live alongside these.
package if_controller_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } if_state_t;

  localparam int DEF_ARRAY_DIM = 8;
  localparam int DEF_CNT_W     = 16;
  localparam int DRAIN_CYCLES  = 2 * DEF_ARRAY_DIM - 1;

  // Cycles needed to push the last real vector through the skewed array.
  function automatic int drain_cycles(input int dim);
    return 2 * dim - 1;
  endfunction

endpackage

// File: rtl/if_addr_gen.sv
// IF buffer address generator: latches the tile base and vector count, advances on
// every read and flags the read that carries the tile's final vector.
module if_addr_gen
  import if_controller_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] base_addr,
  input  logic [CNT_W-1:0] num_vectors,
  input  logic             advance,
  output logic [CNT_W-1:0] if_addr,
  output logic             last
);

  logic [CNT_W-1:0] addr_r;
  logic [CNT_W-1:0] idx_r;
  logic [CNT_W-1:0] n_q_r;

  // Base/count latch on tile launch, address and index advance on each read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_r <= '0;
      idx_r  <= '0;
      n_q_r  <= '0;
    end else if (load) begin
      addr_r <= base_addr;
      idx_r  <= '0;
      n_q_r  <= num_vectors;
    end else if (advance) begin
      addr_r <= addr_r + CNT_W'(1);
      idx_r  <= idx_r + CNT_W'(1);
    end else begin
      addr_r <= addr_r;
      idx_r  <= idx_r;
      n_q_r  <= n_q_r;
    end
  end

  assign if_addr = addr_r;
  // Only consulted during streaming, where the latched count is never zero.
  assign last    = (idx_r == (n_q_r - CNT_W'(1)));

endmodule

// File: rtl/if_controller.sv
// Input-feature controller: streams a tile of IF vectors into the systolic array,
// flushes the skew pipeline with zero bubbles, then hands control back via if_ready.
module if_controller
  import if_controller_pkg::*;
#(
  parameter int ARRAY_DIM = DEF_ARRAY_DIM,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_if,
  input  logic [CNT_W-1:0] num_vectors,
  input  logic [CNT_W-1:0] base_addr,
  input  logic             if_valid,
  output logic             if_rd_en,
  output logic [CNT_W-1:0] if_addr,
  output logic             feed_en,
  output logic             zero_in,
  output logic             if_ready,
  output logic             done
);

  localparam int DRAIN_W = $clog2(2 * ARRAY_DIM);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(drain_cycles(ARRAY_DIM) - 1);

  if_state_t          state_r;
  if_state_t          next_state_s;
  logic [DRAIN_W-1:0] drain_cnt_r;
  logic               rd_en_s;
  logic               rd_en_q_r;
  logic               load_s;
  logic               drain_load_s;
  logic               last_s;
  logic               done_r;

  if_addr_gen #(
    .CNT_W(CNT_W)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (load_s),
    .base_addr  (base_addr),
    .num_vectors(num_vectors),
    .advance    (rd_en_s),
    .if_addr    (if_addr),
    .last       (last_s)
  );

  // Next-state and read-strobe decode; start_if only matters in IDLE.
  always_comb begin
    next_state_s = state_r;
    rd_en_s      = 1'b0;
    load_s       = 1'b0;
    drain_load_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_if) begin
          load_s       = 1'b1;
          next_state_s = (num_vectors != '0) ? STREAM : DONE;
        end else begin
          next_state_s = IDLE;
        end
      end
      STREAM: begin
        rd_en_s = if_valid;
        if (if_valid && last_s) begin
          next_state_s = DRAIN;
          drain_load_s = 1'b1;
        end else begin
          next_state_s = STREAM;
        end
      end
      DRAIN: begin
        if (drain_cnt_r == '0) begin
          next_state_s = DONE;
        end else begin
          next_state_s = DRAIN;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State, drain counter, read-data-present flag and done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      drain_cnt_r <= '0;
      rd_en_q_r   <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      rd_en_q_r <= rd_en_s;
      done_r    <= (next_state_s == DONE);
      if (drain_load_s) begin
        drain_cnt_r <= DRAIN_LOAD;
      end else if ((state_r == DRAIN) && (drain_cnt_r != '0)) begin
        drain_cnt_r <= drain_cnt_r - DRAIN_W'(1);
      end else begin
        drain_cnt_r <= drain_cnt_r;
      end
    end
  end

  assign if_rd_en = rd_en_s;
  assign feed_en  = rd_en_q_r | (state_r == DRAIN);
  assign zero_in  = feed_en & ~rd_en_q_r;
  assign if_ready = (state_r == IDLE);
  assign done     = done_r;

endmodule

// File: tb/tb_if_controller.sv
// Bench for if_controller: each tile's expected per-cycle trace is derived from the
// read schedule (which cycles see if_valid) rather than from any FSM model.
module tb_if_controller;

  localparam int D    = 4;
  localparam int W    = 16;
  localparam int MAXC = 400;

  logic         clk;
  logic         rst;
  logic         start_if;
  logic [W-1:0] num_vectors;
  logic [W-1:0] base_addr;
  logic         if_valid;
  logic         if_rd_en;
  logic [W-1:0] if_addr;
  logic         feed_en;
  logic         zero_in;
  logic         if_ready;
  logic         done;

  int checks;
  int errors;

  bit           v_tab    [0:MAXC-1];
  bit           exp_rd   [0:MAXC-1];
  bit           exp_feed [0:MAXC-1];
  bit           exp_zero [0:MAXC-1];
  bit           exp_done [0:MAXC-1];
  bit           exp_rdy  [0:MAXC-1];
  logic [W-1:0] exp_addr [0:MAXC-1];

  if_controller #(
    .ARRAY_DIM(D),
    .CNT_W    (W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_if   (start_if),
    .num_vectors(num_vectors),
    .base_addr  (base_addr),
    .if_valid   (if_valid),
    .if_rd_en   (if_rd_en),
    .if_addr    (if_addr),
    .feed_en    (feed_en),
    .zero_in    (zero_in),
    .if_ready   (if_ready),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one tile launched at local cycle 0. stall_pct randomises if_valid, stall_at forces
  // one stall cycle, noise toggles start_if/num_vectors/base_addr while busy, held keeps
  // start_if high into the following IDLE cycle (which then launches an N=0 tile).
  task automatic run_tile(input int n, input logic [W-1:0] base, input int stall_pct,
                          input int stall_at, input bit noise, input bit held, input string name);
    int cnt;
    int last_c;
    int end_c;
    int stop_c;
    logic [W-1:0] a;
    for (int c = 0; c < MAXC; c++) begin
      v_tab[c]    = (c > 200) ? 1'b1 : ($urandom_range(99) >= stall_pct);
      exp_rd[c]   = 1'b0;
      exp_feed[c] = 1'b0;
      exp_zero[c] = 1'b0;
      exp_done[c] = 1'b0;
      exp_rdy[c]  = 1'b1;
      exp_addr[c] = '0;
    end
    if (stall_at >= 0) v_tab[stall_at] = 1'b0;
    if (n == 0) begin
      end_c = 1;
    end else begin
      cnt    = 0;
      last_c = 0;
      for (int c = 1; c < 300 && cnt < n; c++) begin
        if (v_tab[c]) begin
          a           = base + W'(cnt);
          exp_rd[c]   = 1'b1;
          exp_addr[c] = a;
          exp_feed[c+1] = 1'b1;
          cnt++;
          last_c = c;
        end
      end
      for (int c = last_c + 1; c <= last_c + 2*D - 1; c++) exp_feed[c] = 1'b1;
      for (int c = 1; c < MAXC; c++) exp_zero[c] = exp_feed[c] && !exp_rd[c-1];
      end_c = last_c + 2*D;
    end
    exp_done[end_c] = 1'b1;
    for (int c = 1; c <= end_c; c++) exp_rdy[c] = 1'b0;
    stop_c = held ? end_c + 2 : end_c + 1;
    for (int c = 0; c <= stop_c; c++) begin
      @(negedge clk);
      if_valid    = v_tab[c];
      num_vectors = W'($urandom_range(50));
      base_addr   = W'($urandom);
      if (c == 0) begin
        start_if    = 1'b1;
        num_vectors = W'(n);
        base_addr   = base;
      end else if (c <= end_c) begin
        start_if = held ? 1'b1 : (noise ? 1'($urandom_range(1)) : 1'b0);
      end else if (held && c == end_c + 1) begin
        start_if    = 1'b1;
        num_vectors = '0;
      end else begin
        start_if = 1'b0;
      end
      #2;
      checks++;
      if (held && c == end_c + 2) begin
        if (done !== 1'b1 || if_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s held_restart c=%0d done=%b ready=%b exp done=1 ready=0",
                   name, c, done, if_ready);
        end
      end else begin
        if (if_rd_en !== exp_rd[c] || feed_en !== exp_feed[c] || zero_in !== exp_zero[c] ||
            done !== exp_done[c] || if_ready !== exp_rdy[c]) begin
          errors++;
          $display("FAIL %s trace c=%0d got rd=%b feed=%b zero=%b done=%b rdy=%b exp rd=%b feed=%b zero=%b done=%b rdy=%b",
                   name, c, if_rd_en, feed_en, zero_in, done, if_ready,
                   exp_rd[c], exp_feed[c], exp_zero[c], exp_done[c], exp_rdy[c]);
        end
        if (exp_rd[c]) begin
          checks++;
          if (if_addr !== exp_addr[c]) begin
            errors++;
            $display("FAIL %s addr c=%0d got=%h exp=%h", name, c, if_addr, exp_addr[c]);
          end
        end
      end
    end
    start_if = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (if_ready !== 1'b1 || if_rd_en !== 1'b0 || feed_en !== 1'b0 || zero_in !== 1'b0 ||
        done !== 1'b0 || if_addr !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state got rdy=%b rd=%b feed=%b zero=%b done=%b addr=%h exp 1 0 0 0 0 0000",
               if_ready, if_rd_en, feed_en, zero_in, done, if_addr);
    end
  endtask

  task automatic test_basic();
    run_tile(4, 16'h0010, 0, -1, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_stall();
    run_tile(4, 16'h0010, 0, 2, 1'b0, 1'b0, "stall");
  endtask

  task automatic test_zero();
    run_tile(0, 16'h0033, 0, -1, 1'b0, 1'b0, "n_zero");
  endtask

  task automatic test_start_held();
    run_tile(3, 16'h0100, 20, -1, 1'b0, 1'b1, "start_held");
    run_tile(5, 16'h0200, 20, -1, 1'b1, 1'b0, "start_noise");
  endtask

  task automatic test_wrap();
    run_tile(3, 16'hFFFE, 0, -1, 1'b0, 1'b0, "wrap");
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    start_if = 1'b1; num_vectors = 16'd10; base_addr = 16'h0040; if_valid = 1'b1;
    @(negedge clk);
    start_if = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (if_ready !== 1'b1 || if_rd_en !== 1'b0 || feed_en !== 1'b0 || done !== 1'b0 ||
        if_addr !== 16'h0000) begin
      errors++;
      $display("FAIL mid_reset got rdy=%b rd=%b feed=%b done=%b addr=%h exp 1 0 0 0 0000",
               if_ready, if_rd_en, feed_en, done, if_addr);
    end
    @(negedge clk);
    rst = 1'b1;
    run_tile(6, 16'h0080, 25, -1, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      run_tile($urandom_range(12), W'($urandom), 35, -1, 1'b1, 1'b0, "random");
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    start_if = 1'b0;
    num_vectors = '0;
    base_addr = '0;
    if_valid = 1'b0;
    #12;
    test_reset();
    rst = 1'b1;
    test_basic();
    test_stall();
    test_zero();
    test_start_held();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_controller.md
Name: if_controller

Overview:
- Input-feature side of the weight/input-feature controller handshake.
- Accepts `start_if` from the weight controller and streams N input-feature vectors from the IF buffer into the systolic array.
- Flushes the array skew pipeline, then raises `if_ready` so the weight controller may switch weight banks and launch the next tile.
- Sits between the weight controller, the IF buffer read port and the array's input shift chain.

Parameters:
- ARRAY_DIM, 8, systolic array rows/cols; sets drain length.
- CNT_W, 16, width of vector count and buffer address.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- start_if  input  1  launch request from weight controller, sampled only in IDLE
- num_vectors  input  CNT_W  vectors to stream this tile, latched with start_if
- base_addr  input  CNT_W  first IF buffer address, latched with start_if
- if_valid  input  1  IF buffer has data at current address
- if_rd_en  output  1  IF buffer read strobe (1-cycle read latency)
- if_addr  output  CNT_W  IF buffer read address
- feed_en  output  1  array input shift enable
- zero_in  output  1  array input mux selects zeros (drain bubbles)
- if_ready  output  1  controller idle / tile finished; handshake back to weight controller
- done  output  1  one-cycle pulse at tile completion

Behaviour:
- States: IDLE, STREAM, DRAIN, DONE. All registers are asynchronously reset when `rst`=0.
- Reset values: state=IDLE, if_addr=0, idx=0, drain_cnt=0, rd_en_q=0, done=0. Outputs `if_rd_en`, `feed_en`, `zero_in` are 0 and `if_ready` is 1 (derived from IDLE).
- `if_ready` = (state==IDLE). It is combinational from the state register, so it drops the cycle after start is accepted.
- IDLE:
  - start_if=1 latches num_vectors into n_q and base_addr into if_addr, and clears idx.
  - Next state is STREAM if num_vectors≠0, else DONE.
  - start_if while not IDLE is ignored; no queuing.
- STREAM:
  - `if_rd_en` = if_valid (combinational).
  - On each if_rd_en: if_addr += 1 and idx += 1.
  - When if_rd_en and idx==n_q−1: go to DRAIN and load drain_cnt = 2*ARRAY_DIM−2.
  - if_valid=0 stalls: if_addr and idx hold, no read.
- rd_en_q = registered if_rd_en; it marks cycles where buffer data is present at the array input.
- `feed_en` = rd_en_q OR (state==DRAIN).
- `zero_in` = feed_en AND NOT rd_en_q.
- DRAIN:
  - Lasts exactly 2*ARRAY_DIM−1 cycles; drain_cnt decrements each cycle.
  - At drain_cnt==0 go to DONE.
  - The first DRAIN cycle carries the last real vector (rd_en_q=1, zero_in=0).
- DONE:
  - Single cycle with done=1 and if_ready=0.
  - Then IDLE; start_if in DONE is ignored.
- Widths: if_addr wraps modulo 2^CNT_W with no error. idx and n_q are CNT_W wide, and num_vectors up to 2^CNT_W−1 is supported.
- Reset asserted mid-tile aborts immediately: state goes to IDLE and any pending read is dropped (rd_en_q=0).

Decomposition:
- Shared package (alongside the weight-controller types):
  - enum if_state_t {IDLE, STREAM, DRAIN, DONE};
  - localparam DRAIN_CYCLES = 2*ARRAY_DIM−1.
- One natural sub-module: if_addr_gen, holding the base latch, incrementer, idx counter and last-vector compare.
- FSM and drain counter stay in the top.

Test Plan:
- Basic run, ARRAY_DIM=4, N=4, base=0x10, if_valid=1, start_if at cycle 0:
  - if_ready low from cycle 1.
  - if_rd_en cycles 1–4 with addr 0x10..0x13.
  - feed_en cycles 2–11, zero_in=0 on cycles 2–5 and 1 on cycles 6–11.
  - done=1 at cycle 12; if_ready=1 at cycle 13.
- Stall, same as above but if_valid=0 at cycle 2:
  - No read at cycle 2; addr holds 0x11.
  - feed_en=0 at cycle 3.
  - done at cycle 13.
- N=0 with start_if: no if_rd_en, no feed_en, done at cycle 1, if_ready=1 at cycle 2.
- start_if held high throughout:
  - Second tile starts only from IDLE at cycle 13.
  - start_if pulses during STREAM/DRAIN/DONE have no effect.
- Reset (rst=0) at cycle 3 mid-STREAM:
  - Asynchronously: if_ready=1, if_rd_en=0, feed_en=0, done=0, if_addr=0.
  - After release, a new start_if runs a clean tile.
- Wrap: base=0xFFFE, N=3, CNT_W=16 -> addresses 0xFFFE, 0xFFFF, 0x0000, normal completion.
